// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter: opcodes, arbiter FSM encoding and width defaults.
package alu_pkg;

  localparam int N_REQ_DEF   = 2;
  localparam int WIDTH_DEF   = 8;
  localparam int OP_W_DEF    = 3;
  localparam int ALU_LAT_DEF = 0;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_NOT  = 3'd5,
    OP_NAND = 3'd6,
    OP_PASS = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  // Width of the round-robin pointer for 2..4 requesters.
  function automatic int ptr_w(input int n);
    return (n > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// One-hot winner selection: round-robin starting after ptr, or fixed lowest-index
// priority when ALU_ARB_PRIORITY_EN is defined (no pointer port then).
module rr_pick
  import alu_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int PTR_W = 1
) (
`ifndef ALU_ARB_PRIORITY_EN
  input  logic [PTR_W-1:0] ptr,
`endif
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] win
);

  always_comb begin
    win = '0;
`ifdef ALU_ARB_PRIORITY_EN
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && (win == '0)) win[i] = 1'b1;
    end
`else
    // Offset k walks ptr+1, ptr+2, ... so the last winner is considered last.
    for (int k = 1; k <= N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if ((j == ((int'(ptr) + k) % N_REQ)) && req[j] && (win == '0)) win[j] = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ requesters: grant, issue, wait ALU_LAT cycles, respond.
// Define ALU_ARB_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int ALU_LAT = ALU_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*OP_W-1:0] req_op,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      done,
  output logic [WIDTH-1:0]      result,
  output logic                  carry,
  output logic [OP_W-1:0]       alu_op,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic                  alu_valid,
  input  logic [WIDTH-1:0]      alu_y,
  input  logic                  alu_co
);

  localparam int         PTR_W  = ptr_w(N_REQ);
  localparam logic [2:0] LAT_M1 = 3'(ALU_LAT - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             alu_valid_q, alu_valid_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0] win;

`ifndef ALU_ARB_PRIORITY_EN
  logic [PTR_W-1:0] ptr_q, ptr_d;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
`ifndef ALU_ARB_PRIORITY_EN
    .ptr (ptr_q),
`endif
    .req (req),
    .win (win)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_d      = done_q;
    alu_valid_d = alu_valid_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    result_d    = result_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
`ifndef ALU_ARB_PRIORITY_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          state_d     = ARB_ISSUE;
          gnt_d       = win;
          alu_valid_d = 1'b1;
          // Operands are frozen here; later requester changes are ignored.
          for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
              alu_op_d = req_op[i*OP_W +: OP_W];
              alu_a_d  = req_a[i*WIDTH +: WIDTH];
              alu_b_d  = req_b[i*WIDTH +: WIDTH];
            end
          end
        end
      end
      ARB_ISSUE: begin
        alu_valid_d = 1'b0;
        if (ALU_LAT == 0) begin
          result_d = alu_y;
          carry_d  = alu_co;
          done_d   = gnt_q;
          state_d  = ARB_RESP;
        end else begin
          cnt_d   = LAT_M1;
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (cnt_q == 3'd0) begin
          result_d = alu_y;
          carry_d  = alu_co;
          done_d   = gnt_q;
          state_d  = ARB_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ARB_RESP: begin
        done_d  = '0;
        gnt_d   = '0;
        state_d = ARB_IDLE;
`ifndef ALU_ARB_PRIORITY_EN
        for (int i = 0; i < N_REQ; i++) begin
          if (gnt_q[i]) ptr_d = PTR_W'(i);
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      alu_valid_q <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
`ifndef ALU_ARB_PRIORITY_EN
      ptr_q       <= PTR_W'(N_REQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      alu_valid_q <= alu_valid_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
`ifndef ALU_ARB_PRIORITY_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_valid = alu_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with two requesters and a two-cycle ALU model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N   = 2;
  localparam int W   = 8;
  localparam int OPW = 3;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*OPW-1:0] req_op;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   gnt, done;
  logic [W-1:0]   result;
  logic           carry;
  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_a, alu_b;
  logic           alu_valid;
  logic [W-1:0]   alu_y;
  logic           alu_co;

  alu_arbiter #(.N_REQ(N), .WIDTH(W), .OP_W(OPW), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .done(done), .result(result), .carry(carry),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_valid(alu_valid),
    .alu_y(alu_y), .alu_co(alu_co)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_NOT:  return {1'b0, ~a};
      OP_NAND: return {1'b0, ~(a & b)};
      default: return {1'b0, a};
    endcase
  endfunction

  // ALU model: output is only correct LAT cycles after the issue cycle, garbage otherwise.
  int         age = 100;
  int         cur_age;
  logic [8:0] alu_full;
  always @(posedge clk) age <= alu_valid ? 1 : ((age < 100) ? age + 1 : age);
  assign cur_age  = alu_valid ? 0 : age;
  assign alu_full = (cur_age == LAT) ? alu_fn(alu_op, alu_a, alu_b) : ~alu_fn(alu_op, alu_a, alu_b);
  assign alu_y    = alu_full[7:0];
  assign alu_co   = alu_full[8];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] res;
    logic       co;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   exp_ptr = N - 1;
  int   cyc = 0;
  int   done_cnt = 0;
  int   last_done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && (done != '0)) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_id", 32'(done), 32'(e.id));
        chk("gnt_resp", 32'(gnt), 32'(e.id));
        chk("result", 32'(result), 32'(e.res));
        chk("carry", 32'(carry), 32'(e.co));
      end
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  task automatic push_exp(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t x;
    logic [8:0] r;
    r    = alu_fn(op, a, b);
    x.id = '0;
    x.id[i] = 1'b1;
    x.res = r[7:0];
    x.co  = r[8];
    sb.push_back(x);
    exp_ptr = i;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[i*OPW +: OPW] = op;
    req_a[i*W +: W]      = a;
    req_b[i*W +: W]      = b;
  endtask

  task automatic wait_issue(output int ci);
    ci = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (alu_valid) begin
        ci = cyc;
        break;
      end
    end
    if (ci < 0) chk("tmo_issue", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 80; k++) begin
      if (done_cnt >= target) break;
      @(posedge clk);
    end
    if (done_cnt < target) chk("tmo_done", 32'(done_cnt), 32'(target));
  endtask

  task automatic run_single(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input bit late, input logic [7:0] late_a);
    int c0, ci, tgt;
    @(posedge clk); #1;
    set_req(i, op, a, b);
    push_exp(i, op, a, b);
    req[i] = 1'b1;
    c0  = cyc;
    tgt = done_cnt + 1;
    wait_issue(ci);
    chk("issue_cyc", 32'(ci), 32'(c0 + 1));
    chk("gnt_issue", 32'(gnt), 32'(1 << i));
    chk("alu_a_issue", 32'(alu_a), 32'(a));
    req[i] = 1'b0;
    if (late) begin
      @(posedge clk); #1;
      req_a[i*W +: W] = late_a;
    end
    wait_done(tgt);
    chk("done_cyc", 32'(last_done_cyc), 32'(c0 + 2 + LAT));
    #1;
    chk("gnt_idle", 32'(gnt), 32'd0);
    chk("valid_idle", 32'(alu_valid), 32'd0);
    chk("alu_a_hold", 32'(alu_a), 32'(a));
  endtask

  initial begin
    int ci, tgt, saved, w, dd;
    int d[4];
    rst_n  = 1'b0;
    req    = '0;
    req_op = '0;
    req_a  = '0;
    req_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(alu_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    rst_n = 1'b1;

    run_single(0, OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h00);
    run_single(0, OP_ADD, 8'h10, 8'h01, 1'b1, 8'hFF);
    run_single(1, OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00);
    run_single(1, OP_SUB, 8'h05, 8'h07, 1'b0, 8'h00);
    run_single(0, OP_NOT, 8'h5A, 8'h00, 1'b0, 8'h00);
    run_single(1, OP_PASS, 8'hC3, 8'h11, 1'b0, 8'h00);

    // Contention: both held for four operations.
    @(posedge clk); #1;
    set_req(0, OP_AND, 8'hF0, 8'h3C);
    set_req(1, OP_OR, 8'h0F, 8'h30);
`ifdef ALU_ARB_PRIORITY_EN
    for (int n = 0; n < 4; n++) push_exp(0, OP_AND, 8'hF0, 8'h3C);
`else
    w = (exp_ptr + 1) % N;
    for (int n = 0; n < 4; n++) begin
      if (w == 0) push_exp(0, OP_AND, 8'hF0, 8'h3C);
      else        push_exp(1, OP_OR, 8'h0F, 8'h30);
      w = (w + 1) % N;
    end
`endif
    req = 2'b11;
    tgt = done_cnt;
    for (int n = 0; n < 3; n++) begin
      wait_done(tgt + n + 1);
      d[n] = last_done_cyc;
    end
    wait_issue(ci);
    req = 2'b00;
    wait_done(tgt + 4);
    d[3] = last_done_cyc;
    for (int n = 1; n < 4; n++) chk("rr_gap", 32'(d[n] - d[n-1]), 32'(LAT + 3));

    // Last served is requester 0, so only reset can make 0 win first again.
    run_single(0, OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h00);
    @(posedge clk); #1;
    set_req(0, OP_XOR, 8'h33, 8'h0F);
    req[0] = 1'b1;
    wait_issue(ci);
    req[0] = 1'b0;
    @(posedge clk); #1;
    saved = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_gnt", 32'(gnt), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_valid", 32'(alu_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_carry", 32'(carry), 32'd0);
    chk("abort_alu_a", 32'(alu_a), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt), 32'(saved));

    exp_ptr = N - 1;
    set_req(0, OP_XOR, 8'h33, 8'h0F);
    set_req(1, OP_NAND, 8'hF0, 8'h3C);
    push_exp(0, OP_XOR, 8'h33, 8'h0F);
    push_exp(1, OP_NAND, 8'hF0, 8'h3C);
    tgt = done_cnt;
    req = 2'b11;
    wait_issue(ci);
    chk("post_rst_gnt", 32'(gnt), 32'd1);
    req[0] = 1'b0;
    wait_done(tgt + 1);
    dd = last_done_cyc;
    wait_issue(ci);
    chk("rearb_cyc", 32'(ci), 32'(dd + 2));
    chk("rearb_gnt", 32'(gnt), 32'd2);
    req[1] = 1'b0;
    wait_done(tgt + 2);
    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("final_gnt", 32'(gnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one ALU datapath instance between up to four requesters. Each requester presents an opcode and two operands with a level request; the arbiter picks one requester per operation, drives the ALU inputs, waits a fixed ALU latency, captures result and carry, and returns them with a one-cycle done pulse. It sits between the requester blocks (sequencers, test drivers) and the gate-level ALU.

## Interface
- `N_REQ`, 2: number of requesters, legal 2..4.
- `WIDTH`, 8: operand/result width.
- `OP_W`, 3: opcode width.
- `ALU_LAT`, 0: ALU latency in cycles, legal 0..7; 0 means purely combinational.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  N_REQ  per-requester request level.
- `req_op`  in  N_REQ*OP_W  packed opcodes, requester i at [i*OP_W +: OP_W].
- `req_a`, `req_b`  in  N_REQ*WIDTH  packed operands.
- `gnt`  out  N_REQ  one-hot grant; zero when idle.
- `done`  out  N_REQ  one-hot, one-cycle completion pulse.
- `result`  out  WIDTH  last captured ALU result.
- `carry`  out  1  last captured ALU carry.
- `alu_op`  out  OP_W  to ALU.
- `alu_a`, `alu_b`  out  WIDTH  to ALU.
- `alu_valid`  out  1  high for the ISSUE cycle.
- `alu_y`  in  WIDTH  ALU result.
- `alu_co`  in  1  ALU carry out.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req` is high, choose a winner, latch its op/a/b into internal registers, and go to ISSUE. Otherwise stay.
- ISSUE: `gnt[w]`=1 and `alu_valid`=1; `alu_*` driven from the latched registers. Go to WAIT if ALU_LAT>0, else capture `alu_y`/`alu_co` and go to RESP.
- WAIT: a down-counter loaded with ALU_LAT-1 in ISSUE. At count 0, capture and go to RESP.
- RESP: `done[w]`=1 and `gnt[w]`=1. Go to IDLE and update the round-robin pointer to w.
- Round-robin: search starts at pointer+1 modulo N_REQ. The pointer resets to N_REQ-1, so requester 0 wins first.
- Operands are latched at grant, so requester changes after the IDLE decision have no effect.
- Dropping `req` mid-operation does not abort it; `done` still pulses.
- A requester holding `req` high after `done` is re-arbitrated in the next IDLE cycle.
- `alu_op`/`alu_a`/`alu_b` hold their latched values outside ISSUE; no toggling when idle.
- `result`/`carry` hold until the next capture.
- `req` bits at index ≥ N_REQ do not exist; the request vector is exactly N_REQ wide.

## Timing
- Reset values: state IDLE; `gnt`=0, `done`=0, `alu_valid`=0, `result`=0, `carry`=0, `alu_op`/`alu_a`/`alu_b`=0, counter=0.
- Reset is asynchronous. Asserting it mid-operation aborts immediately; no `done` is issued for the aborted operation.
- `req` high in IDLE at cycle t gives:
  - ISSUE at t+1;
  - `done` at t+2+ALU_LAT, with `result` valid in that same cycle.
- Back-to-back throughput: one operation per ALU_LAT+3 cycles.
- `alu_y` is sampled at the clock edge ending the last ISSUE (ALU_LAT=0) or WAIT cycle.

## Configuration
- `ALU_ARB_PRIORITY_EN` defined: fixed priority, lowest index wins. The round-robin pointer is not implemented.
- Without the macro: round-robin as described above.

## Structure
- Shared package `alu_pkg` holds:
  - the opcode constants (ADD, SUB, AND, OR, XOR, NOT, NAND, PASS);
  - the FSM state encoding `ARB_IDLE`..`ARB_RESP` (2 bits);
  - the width defaults.
- One natural sub-module: `rr_pick`. Combinational; inputs are the request vector and pointer; output is the one-hot winner. It also implements fixed priority under the macro.

## Test plan
- Single request (N_REQ=2, ALU_LAT=0): req0, op ADD, a=8'h7F, b=8'h01 at cycle 1 → `gnt[0]` in cycles 2–3, `done[0]` at cycle 3, `result`=8'h80, `carry`=0.
- Contention: req0 and req1 both held, ALU_LAT=2 → grants alternate 0,1,0,1; each `done` 5 cycles apart. With `ALU_ARB_PRIORITY_EN`, only requester 0 is served.
- Operand stability: change `req_a[0]` from 8'h10 to 8'hFF during WAIT, op ADD, b=8'h01 → `result`=8'h11.
- Request withdrawn: drop req1 in ISSUE → `done[1]` still pulses, then the FSM returns to IDLE with `gnt`=0.
- Reset mid-op: assert `rst_n`=0 during WAIT → all outputs 0 immediately, no `done`. Next request is served by requester 0 first.
- Carry path: op ADD, a=8'hFF, b=8'h01, ALU_LAT=3 → `result`=8'h00, `carry`=1, `done` at t+5.
